// File: rtl/lockable_cfg_arbiter.sv
// Round-robin arbiter sequencing WRITE/LOCK requests into a bank of sticky-lockable
// 16-bit config registers; scan entry wipes the bank contents but never the locks.
module lockable_cfg_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned AW       = 3
) (
    input  logic                   Clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [NUM_REQ*AW-1:0]  req_addr,
    input  logic [NUM_REQ*16-1:0]  req_data,
    input  logic                   scan_mode,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [NUM_REGS-1:0]    lock_q,
    output logic [NUM_REGS*16-1:0] Data_out
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e        state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] idx_q;
    logic          op_lock_q;
    logic [AW-1:0] op_addr_q;
    logic [15:0]   op_data_q;
    logic          scan_q;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] cand;
    logic [IW-1:0] rr_ptr_d;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            cand = IW'((32'(rr_ptr_q) + o) % NUM_REQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        rr_ptr_d = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    logic addr_oor;
    logic addr_locked;
    logic exec_err;

    always_comb begin
        addr_oor    = 32'(op_addr_q) >= NUM_REGS;
        addr_locked = 1'b0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (op_addr_q == AW'(k) && lock_q[k]) begin
                addr_locked = 1'b1;
            end
        end
        // LOCK never checks the existing lock bit, so re-locking is accepted.
        exec_err = addr_oor | scan_mode | (~op_lock_q & addr_locked);
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            op_lock_q <= 1'b0;
            op_addr_q <= '0;
            op_data_q <= '0;
            scan_q    <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            lock_q    <= '0;
            Data_out  <= '0;
        end else begin
            scan_q <= scan_mode;
            case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        idx_q     <= sel_idx;
                        op_lock_q <= req_lock[sel_idx];
                        op_addr_q <= req_addr[int'(sel_idx) * AW +: AW];
                        op_data_q <= req_data[int'(sel_idx) * 16 +: 16];
                        gnt       <= NUM_REQ'(1) << sel_idx;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    gnt         <= '0;
                    done[idx_q] <= 1'b1;
                    err         <= exec_err;
                    state_q     <= StResp;
                    if (!exec_err) begin
                        for (int unsigned k = 0; k < NUM_REGS; k++) begin
                            if (op_addr_q == AW'(k)) begin
                                if (op_lock_q) begin
                                    lock_q[k] <= 1'b1;
                                end else begin
                                    Data_out[k*16 +: 16] <= op_data_q;
                                end
                            end
                        end
                    end
                end
                StResp: begin
                    done    <= '0;
                    err     <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            // Scan-entry wipe is last so it wins over a same-edge write.
            if (scan_mode && !scan_q) begin
                Data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lockable_cfg_arbiter.sv
// Bench for lockable_cfg_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter and bank.
module tb_lockable_cfg_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 6;
    localparam int AW       = 3;

    logic                   Clk = 1'b0;
    logic                   resetn;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_lock;
    logic [NUM_REQ*AW-1:0]  req_addr;
    logic [NUM_REQ*16-1:0]  req_data;
    logic                   scan_mode;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     done;
    logic                   err;
    logic [NUM_REGS-1:0]    lock_q;
    logic [NUM_REGS*16-1:0] Data_out;

    lockable_cfg_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REGS(NUM_REGS),
        .AW      (AW)
    ) dut (
        .Clk      (Clk),
        .resetn   (resetn),
        .req      (req),
        .req_lock (req_lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .scan_mode(scan_mode),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .lock_q   (lock_q),
        .Data_out (Data_out)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            if (n_errs <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: one transaction in flight, tracked by cycles elapsed since its grant.
    int          m_phase;
    int          m_ptr;
    int          m_idx;
    logic        m_op_lock;
    int          m_addr;
    logic [15:0] m_data;
    logic        m_err;
    logic        m_scan_prev;
    logic [15:0] m_regs [NUM_REGS];
    logic        m_lock [NUM_REGS];

    function automatic void model_reset();
        m_phase     = 0;
        m_ptr       = 0;
        m_idx       = 0;
        m_err       = 1'b0;
        m_scan_prev = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            m_regs[k] = '0;
            m_lock[k] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        logic rise;
        rise = scan_mode && !m_scan_prev;
        m_scan_prev = scan_mode;
        if (m_phase == 0) begin
            for (int o = 0; o < NUM_REQ; o++) begin
                int c;
                c = (m_ptr + o) % NUM_REQ;
                if (req[c]) begin
                    m_idx     = c;
                    m_op_lock = req_lock[c];
                    m_addr    = int'(req_addr[c*AW +: AW]);
                    m_data    = req_data[c*16 +: 16];
                    m_ptr     = (c + 1) % NUM_REQ;
                    m_phase   = 1;
                    break;
                end
            end
        end else if (m_phase == 1) begin
            if (m_addr >= NUM_REGS || scan_mode) begin
                m_err = 1'b1;
            end else if (m_op_lock) begin
                m_lock[m_addr] = 1'b1;
                m_err = 1'b0;
            end else if (m_lock[m_addr]) begin
                m_err = 1'b1;
            end else begin
                m_regs[m_addr] = m_data;
                m_err = 1'b0;
            end
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
        if (rise) begin
            for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        end
    endfunction

    function automatic logic [NUM_REGS*16-1:0] model_bank();
        logic [NUM_REGS*16-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[k*16 +: 16] = m_regs[k];
        return v;
    endfunction

    function automatic logic [NUM_REGS-1:0] model_locks();
        logic [NUM_REGS-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[k] = m_lock[k];
        return v;
    endfunction

    always @(negedge Clk) begin
        logic [NUM_REQ-1:0] eg;
        logic [NUM_REQ-1:0] ed;
        eg = (m_phase == 1) ? NUM_REQ'(1) << m_idx : '0;
        ed = (m_phase == 2) ? NUM_REQ'(1) << m_idx : '0;
        check("gnt", gnt, eg);
        check("done", done, ed);
        check("err", err, (m_phase == 2) ? m_err : 1'b0);
        check("lock_q", lock_q, model_locks());
        check("Data_out", Data_out, model_bank());
        check("gnt_onehot0", $countones(gnt) <= 1, 1'b1);
    end

    task automatic cycle();
        @(posedge Clk);
        if (resetn) model_step();
        #1;
    endtask

    task automatic set_req(input int i, input logic lk, input int addr, input logic [15:0] d);
        req_lock[i]          = lk;
        req_addr[i*AW +: AW] = AW'(addr);
        req_data[i*16 +: 16] = d;
        req[i]               = 1'b1;
    endtask

    task automatic do_op(input int i, input logic lk, input int addr, input logic [15:0] d,
                         output logic e);
        logic got;
        got = 1'b0;
        e   = 1'b0;
        set_req(i, lk, addr, d);
        for (int n = 0; n < 20 && !got; n++) begin
            cycle();
            if (done[i]) begin
                got = 1'b1;
                e   = err;
            end
        end
        if (!got) begin
            n_checks++;
            n_errs++;
            $display("FAIL done_timeout: requester %0d got no done, required within 20 cycles", i);
        end
        req[i] = 1'b0;
        cycle();
    endtask

    logic                   e;
    logic [NUM_REGS*16-1:0] exp_bank;
    logic [NUM_REQ-1:0]     order [8];
    int                     cnt;

    initial begin
        resetn    = 1'b0;
        req       = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
        scan_mode = 1'b0;
        model_reset();
        cycle();
        cycle();
        check("reset_gnt", gnt, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_lock", lock_q, 0);
        check("reset_data", Data_out, 0);
        resetn = 1'b1;
        cycle();

        // Basic write with latency
        set_req(0, 1'b0, 2, 16'hA5A5);
        cycle();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_no_done", done, 0);
        cycle();
        check("t1_done", done, 4'b0001);
        check("t1_err", err, 0);
        check("t1_data2", Data_out[2*16 +: 16], 16'hA5A5);
        req[0] = 1'b0;
        cycle();

        // Lock then rejected write
        do_op(1, 1'b1, 2, 16'h0000, e);
        check("t2_lock_err", e, 0);
        do_op(1, 1'b0, 2, 16'h1234, e);
        check("t2_wr_locked_err", e, 1);
        check("t2_data2", Data_out[2*16 +: 16], 16'hA5A5);

        // Out-of-range and re-lock
        exp_bank = '0;
        exp_bank[2*16 +: 16] = 16'hA5A5;
        do_op(2, 1'b0, 7, 16'hBEEF, e);
        check("t5_oor7_err", e, 1);
        do_op(2, 1'b0, 6, 16'hBEEF, e);
        check("t5_oor6_err", e, 1);
        check("t5_bank", Data_out, exp_bank);
        do_op(3, 1'b1, 2, 16'h0000, e);
        check("t5_relock_err", e, 0);
        check("t5_locks", lock_q, 6'b000100);
        check("t5_bank2", Data_out, exp_bank);

        // Scan entry
        scan_mode = 1'b1;
        cycle();
        check("t4_wipe", Data_out, 0);
        check("t4_locks", lock_q, 6'b000100);
        do_op(0, 1'b0, 2, 16'h7777, e);
        check("t4_scan_wr_err", e, 1);
        do_op(0, 1'b1, 3, 16'h0000, e);
        check("t4_scan_lock_err", e, 1);
        check("t4_locks2", lock_q, 6'b000100);
        scan_mode = 1'b0;
        cycle();
        do_op(1, 1'b0, 4, 16'h5A5A, e);
        check("t4_post_err", e, 0);
        check("t4_post_d4", Data_out[4*16 +: 16], 16'h5A5A);
        check("t4_post_d2", Data_out[2*16 +: 16], 16'h0000);

        // Fairness: steer pointer to 0, then all four request continuously
        do_op(3, 1'b0, 0, 16'h1111, e);
        set_req(0, 1'b0, 0, 16'h1000);
        set_req(1, 1'b0, 1, 16'h2001);
        set_req(2, 1'b0, 3, 16'h3003);
        set_req(3, 1'b0, 5, 16'h4005);
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 8; n++) begin
            cycle();
            if (gnt != 0) begin
                order[cnt] = gnt;
                cnt++;
            end
        end
        req = '0;
        check("t3_count", cnt, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_order%0d", k), order[k], NUM_REQ'(1) << (k % 4));
        end
        repeat (4) cycle();

        // Reset during EXEC
        set_req(2, 1'b1, 1, 16'h0000);
        cycle();
        check("t6_gnt_pre", gnt, 4'b0100);
        resetn = 1'b0;
        model_reset();
        #1;
        check("t6_gnt", gnt, 0);
        check("t6_done", done, 0);
        check("t6_lock", lock_q, 0);
        check("t6_data", Data_out, 0);
        req = '0;
        cycle();
        cycle();
        resetn = 1'b1;
        set_req(3, 1'b0, 0, 16'hAAAA);
        set_req(1, 1'b0, 1, 16'hBBBB);
        cycle();
        check("t6_first_gnt", gnt, 4'b0010);
        req = '0;
        repeat (4) cycle();

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cycle();
            if ($urandom_range(0, 499) == 0) begin
                resetn = 1'b0;
                model_reset();
                req = '0;
                cycle();
                cycle();
                resetn = 1'b1;
            end else begin
                if ($urandom_range(0, 79) == 0) scan_mode = ~scan_mode;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req[i] && (done[i] || $urandom_range(0, 49) == 0)) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                        set_req(i, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
                                16'($urandom));
                    end
                end
            end
        end
        req = '0;
        scan_mode = 1'b0;
        repeat (5) cycle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
